// File: rtl/spi_ram_wrapper_if.sv
// SPI pin bundle between an external master and the RAM wrapper slave.
interface spi_ram_wrapper_if;
    logic mosi;
    logic ss_n;
    logic miso;

    modport master (
        output mosi,
        output ss_n,
        input  miso
    );

    modport slave (
        input  mosi,
        input  ss_n,
        output miso
    );
endinterface

// File: rtl/spi_ram_wrapper.sv
// SPI slave front-end with an internal RAM and separate write/read address pointers.
// A 10-bit frame carries a 2-bit command plus an 8-bit payload:
//   00 sets the write address, 01 writes RAM, 10 sets the read address,
//   11 streams RAM[read address] back on miso, MSB first.
module spi_ram_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_ram_wrapper_if.slave    spi
);

    localparam int FRAME_W = DATA_SIZE + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RX,
        READOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    // Holds the first nine frame bits; the tenth is taken straight from mosi
    // on the decode edge, so the full frame is always {rxShift_q, mosi}.
    logic [FRAME_W-2:0]     rxShift_q, rxShift_d;
    logic [ADDR_SIZE-1:0]   wrAddr_q, wrAddr_d;
    logic [ADDR_SIZE-1:0]   rdAddr_q, rdAddr_d;
    logic [DATA_SIZE-1:0]   tx_q, tx_d;
    logic                   miso_q, miso_d;
    // Cleared when a frame completes; set again once ss_n is seen high, so a
    // new frame only starts after the master has deselected the slave.
    logic                   armed_q, armed_d;

    logic [FRAME_W-1:0]     rxFull;
    logic                   ramWe;
    logic [DATA_SIZE-1:0]   ramRdata;
    logic [DATA_SIZE-1:0]   mem [MEM_DEPTH];

    assign rxFull   = {rxShift_q, spi.mosi};
    assign ramRdata = mem[rdAddr_q];
    assign spi.miso = miso_q;

    // Next-state logic: frame reception, command decode and readout sequencing.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        rxShift_d = rxShift_q;
        wrAddr_d  = wrAddr_q;
        rdAddr_d  = rdAddr_q;
        tx_d      = tx_q;
        miso_d    = 1'b0;
        armed_d   = spi.ss_n ? 1'b1 : armed_q;
        ramWe     = 1'b0;

        case (state_q)
            IDLE: begin
                bitCnt_d = '0;
                if (!spi.ss_n && armed_q) begin
                    rxShift_d = {{(FRAME_W-2){1'b0}}, spi.mosi};
                    bitCnt_d  = CNT_W'(1);
                    state_d   = RX;
                end
            end

            RX: begin
                if (spi.ss_n) begin
                    bitCnt_d = '0;
                    state_d  = IDLE;
                end else if (bitCnt_q == CNT_W'(FRAME_W - 1)) begin
                    bitCnt_d = '0;
                    armed_d  = 1'b0;
                    state_d  = IDLE;
                    case (rxFull[FRAME_W-1 -: 2])
                        2'b00:   wrAddr_d = rxFull[ADDR_SIZE-1:0];
                        2'b01:   ramWe    = 1'b1;
                        2'b10:   rdAddr_d = rxFull[ADDR_SIZE-1:0];
                        default: state_d  = READOUT;
                    endcase
                end else begin
                    rxShift_d = rxFull[FRAME_W-2:0];
                    bitCnt_d  = bitCnt_q + 1'b1;
                end
            end

            READOUT: begin
                if (spi.ss_n) begin
                    bitCnt_d = '0;
                    state_d  = IDLE;
                end else if (bitCnt_q == '0) begin
                    tx_d     = ramRdata;
                    miso_d   = ramRdata[DATA_SIZE-1];
                    bitCnt_d = CNT_W'(1);
                end else if (bitCnt_q < CNT_W'(DATA_SIZE)) begin
                    tx_d     = tx_q << 1;
                    miso_d   = tx_q[DATA_SIZE-2];
                    bitCnt_d = bitCnt_q + 1'b1;
                end else begin
                    bitCnt_d = '0;
                    state_d  = IDLE;
                end
            end

            default: begin
                bitCnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and datapath registers; RAM contents live outside this reset domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            rxShift_q <= '0;
            wrAddr_q  <= '0;
            rdAddr_q  <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            rxShift_q <= rxShift_d;
            wrAddr_q  <= wrAddr_d;
            rdAddr_q  <= rdAddr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            armed_q   <= armed_d;
        end
    end

    // RAM write port, driven by a decoded write-data frame.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[wrAddr_q] <= rxFull[DATA_SIZE-1:0];
        end
    end

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Directed bench for spi_ram_wrapper: address, write, read-back, aborts and reset.
module tb_spi_ram_wrapper;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    spi_ram_wrapper_if spi ();

    spi_ram_wrapper #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .DATA_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift the top nbits of a frame into the slave, one bit per clock,
    // driving on the falling edge so the rising edge samples a stable value.
    task automatic applyStimulus(input logic [9:0] frame, input int nbits);
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            spi.ss_n = 1'b0;
            spi.mosi = frame[i];
            @(posedge clk);
        end
    endtask

    // Compare miso against an expected value and tally the result.
    task automatic checkOutput(input string tag, input logic expected);
        checks++;
        assert (spi.miso === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, spi.miso, expected);
        end
    endtask

    // Deselect the slave for a couple of clocks so it re-arms.
    task automatic endFrame();
        @(negedge clk);
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Issue a read-data frame and check the serialised byte, then idle with
    // ss_n still low (mosi high) for extraClocks and confirm miso stays 0.
    task automatic readByte(input string tag, input logic [7:0] expected, input int extraClocks);
        logic [7:0] expVal;
        expVal = expected;
        applyStimulus({2'b11, 8'h6E}, 10);
        @(negedge clk);
        checkOutput({tag, "_pre"}, 1'b0);
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            checkOutput($sformatf("%s_bit%0d", tag, b), expVal[b]);
        end
        @(negedge clk);
        checkOutput({tag, "_post"}, 1'b0);
        spi.mosi = 1'b1;
        for (int k = 0; k < extraClocks; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_idle%0d", tag, k), 1'b0);
        end
        endFrame();
    endtask

    // Directed sequence of stimulus steps.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;

        repeat (25) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_miso", 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_miso", 1'b0);

        // Write 0x5C at the default write address 0, read from default read address 0.
        applyStimulus({2'b01, 8'h5C}, 10);
        @(negedge clk);
        checkOutput("write5c_miso", 1'b0);
        endFrame();
        readByte("rd_default0", 8'h5C, 0);

        // Set write address 1.
        applyStimulus({2'b00, 8'h01}, 10);
        @(negedge clk);
        checkOutput("wraddr_miso", 1'b0);
        endFrame();

        // Write 0xAA to address 1, point reads at 1, read with ss_n held low long.
        applyStimulus({2'b01, 8'hAA}, 10);
        endFrame();
        applyStimulus({2'b10, 8'h01}, 10);
        endFrame();
        readByte("rd_addr1", 8'hAA, 15);

        // Address 0 must still hold 0x5C, so the 0xAA write went to address 1.
        applyStimulus({2'b10, 8'h00}, 10);
        endFrame();
        readByte("rd_addr0", 8'h5C, 0);

        // Partial write frame aborted after 6 bits must leave RAM untouched.
        applyStimulus({2'b10, 8'h01}, 10);
        endFrame();
        applyStimulus({2'b01, 8'hF0}, 6);
        endFrame();
        readByte("rd_after_abort", 8'hAA, 0);

        // Reset during readout: miso drops at once, RAM survives.
        applyStimulus({2'b11, 8'h00}, 10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("readout_b7_before_reset", 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_miso", 1'b0);
        @(negedge clk);
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("after_reset_release", 1'b0);
        applyStimulus({2'b10, 8'h01}, 10);
        endFrame();
        readByte("rd_retained", 8'hAA, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
